// File: rtl/ofmap_bank_writer.sv
// Write side of the column-banked feature-map RAM array.
// Scatters ROWS-lane beats into per-column banks, one map row per address.
module ofmap_bank_writer #(
  parameter int DW       = 8,
  parameter int ROWS     = 8,
  parameter int RAM_NUM  = 32,
  parameter int RAM_SIZE = 32,
  parameter int ADDR_W   = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [5:0]             out_w,
  input  logic [5:0]             out_h,
  input  logic [ADDR_W-1:0]      image_base,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW*ROWS-1:0]     in_data,
  output logic [RAM_NUM-1:0]     wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DW*RAM_NUM-1:0]  wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  localparam int LW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [6:0] RW   = 7'(ROWS);
  localparam logic [6:0] WMAX = 7'(RAM_NUM);
  localparam logic [6:0] HMAX = 7'(RAM_SIZE);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [6:0]              x_q, x_d;
  logic [6:0]              y_q, y_d;
  logic [6:0]              w_q, w_d;
  logic [6:0]              h_q, h_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [RAM_NUM-1:0]      en_q, en_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DW*RAM_NUM-1:0]   data_q, data_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic                    cfg_ok;
  logic                    last_col;
  logic                    last_row;
  logic [DW-1:0]           lane [ROWS];
  logic [6:0]              bi;
  logic [6:0]              off;

  // Unpack the input beat into per-lane pixels.
  always_comb begin
    for (int j = 0; j < ROWS; j++) begin
      lane[j] = in_data[DW*j +: DW];
    end
  end

  assign in_ready = (state_q == RUN);
  assign busy     = (state_q == RUN);
  assign accept   = (state_q == RUN) & in_valid;

  assign cfg_ok = (out_w != 6'd0) && ({1'b0, out_w} <= WMAX) &&
                  (out_h != 6'd0) && ({1'b0, out_h} <= HMAX);

  assign last_col = (x_q + RW) >= w_q;
  assign last_row = (y_q == (h_q - 7'd1));

  // Next-state logic: map walk, config latch and the write-port image.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    base_d  = base_q;
    en_d    = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    bi      = '0;
    off     = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            w_d     = {1'b0, out_w};
            h_d     = {1'b0, out_h};
            base_d  = image_base;
            x_d     = '0;
            y_d     = '0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          data_d = '0;
          addr_d = base_q + ADDR_W'(y_q);
          for (int b = 0; b < RAM_NUM; b++) begin
            bi  = 7'(b);
            off = bi - x_q;
            if (bi >= x_q && bi < (x_q + RW) && bi < w_q) begin
              en_d[b]           = 1'b1;
              data_d[DW*b +: DW] = lane[LW'(off)];
            end
          end
          if (last_col) begin
            x_d = '0;
            y_d = y_q + 7'd1;
            if (last_row) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            x_d = x_q + RW;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      base_q  <= '0;
      en_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      base_q  <= base_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wr_en   = en_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;
  assign done    = done_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_ofmap_bank_writer.sv
// Bench for ofmap_bank_writer: reference model feeds a write scoreboard,
// table of map configs plus hand sequences for stalls, wrap and reset.
module tb_ofmap_bank_writer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [5:0]   out_w, out_h;
  logic [8:0]   image_base;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic [31:0]  wr_en;
  logic [8:0]   wr_addr;
  logic [255:0] wr_data;
  logic         busy, done, cfg_err;

  ofmap_bank_writer dut (
    .clk(clk), .rst(rst), .start(start),
    .out_w(out_w), .out_h(out_h), .image_base(image_base),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  en;
    logic [8:0]   addr;
    logic [255:0] data;
    logic         dn;
  } exp_t;

  typedef struct {
    int w;
    int h;
    int base;
    int beats;
    bit err;
  } vec_t;

  exp_t         sb[$];
  logic [31:0]  seen_en[$];
  logic [8:0]   seen_addr[$];
  logic [255:0] seen_d[$];

  int  total = 0;
  int  bad   = 0;
  bit  m_run;
  int  m_x, m_y, m_w, m_h, m_base;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_seen();
    seen_en.delete();
    seen_addr.delete();
    seen_d.delete();
  endtask

  // One clock: drive at negedge, update model, check #1 after posedge.
  task automatic cyc(input bit st, input int w, input int h, input int b,
                     input bit v, input logic [63:0] d);
    exp_t e;
    bit   ce;
    int   idx;
    logic [63:0] dd;
    start      = st;
    out_w      = 6'(w);
    out_h      = 6'(h);
    image_base = 9'(b);
    in_valid   = v;
    in_data    = d;
    ce         = 1'b0;
    #1;
    chk("in_ready_pre", in_ready, m_run);
    if (v && m_run) begin
      e.en   = '0;
      e.data = '0;
      e.addr = 9'((m_base + m_y) % 512);
      dd     = d;
      for (int j = 0; j < 8; j++) begin
        idx = m_x + j;
        if (idx < m_w) begin
          e.en[idx]          = 1'b1;
          e.data[8*idx +: 8] = dd[8*j +: 8];
        end
      end
      e.dn = (m_x + 8 >= m_w) && (m_y == m_h - 1);
      sb.push_back(e);
      if (m_x + 8 >= m_w) begin
        m_x = 0;
        m_y++;
        if (e.dn) m_run = 1'b0;
      end else begin
        m_x += 8;
      end
    end else if (st && !m_run) begin
      if (w >= 1 && w <= 32 && h >= 1 && h <= 32) begin
        m_run = 1'b1; m_x = 0; m_y = 0;
        m_w = w; m_h = h; m_base = b;
      end else begin
        ce = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (wr_en != '0) begin
      seen_en.push_back(wr_en);
      seen_addr.push_back(wr_addr);
      seen_d.push_back(wr_data);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("wr_en", wr_en, e.en);
      chk("wr_addr", wr_addr, e.addr);
      chk("wr_data", wr_data, e.data);
      chk("done", done, e.dn);
    end else begin
      chk("idle_wr_en", wr_en, 0);
      chk("idle_done", done, 0);
    end
    chk("cfg_err", cfg_err, ce);
    chk("busy", busy, m_run);
    chk("in_ready", in_ready, m_run);
    @(negedge clk);
  endtask

  task automatic run_map(input int w, input int h, input int b);
    int n;
    clear_seen();
    cyc(1'b1, w, h, b, 1'b0, 64'h0);
    n = 0;
    while (m_run && n < 2000) begin
      cyc(1'b0, 0, 0, 0, 1'b1, {$urandom, $urandom});
      n++;
    end
    if (m_run) chk("map_timeout", m_run, 0);
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{28, 2, 0,   8,   1'b0};
    vt[1] = '{8,  1, 5,   1,   1'b0};
    vt[2] = '{8,  4, 510, 4,   1'b0};
    vt[3] = '{32, 2, 3,   8,   1'b0};
    vt[4] = '{1,  1, 7,   1,   1'b0};
    vt[5] = '{17, 3, 500, 9,   1'b0};
    vt[6] = '{32, 32, 100, 128, 1'b0};
    vt[7] = '{0,  3, 0,   0,   1'b1};
    vt[8] = '{33, 1, 0,   0,   1'b1};
    vt[9] = '{5,  0, 0,   0,   1'b1};

    m_run = 1'b0; m_x = 0; m_y = 0;
    m_w = 0; m_h = 0; m_base = 0;
    rst = 1'b1; start = 1'b0; out_w = '0; out_h = '0;
    image_base = '0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_map(vt[i].w, vt[i].h, vt[i].base);
      chk($sformatf("beats_%0d", i), seen_en.size(), vt[i].beats);
      if (i == 0 && seen_en.size() == 8) begin
        chk("t1_beat4_en", seen_en[3], 32'h0F00_0000);
        chk("t1_row0_addr", seen_addr[3], 0);
        chk("t1_row1_addr", seen_addr[4], 1);
      end
      if (i == 2 && seen_addr.size() == 4) begin
        chk("t4_a0", seen_addr[0], 510);
        chk("t4_a1", seen_addr[1], 511);
        chk("t4_a2", seen_addr[2], 0);
        chk("t4_a3", seen_addr[3], 1);
      end
    end

    // single full beat: exact bank image
    clear_seen();
    cyc(1'b1, 8, 1, 5, 1'b0, 64'h0);
    cyc(1'b0, 0, 0, 0, 1'b1, 64'h0706050403020100);
    chk("t2_writes", seen_en.size(), 1);
    if (seen_en.size() == 1) begin
      chk("t2_en", seen_en[0], 32'h0000_00FF);
      chk("t2_addr", seen_addr[0], 5);
      chk("t2_bank3", seen_d[0][31:24], 8'h03);
    end

    // stalls with valid low, then toggled valid
    clear_seen();
    cyc(1'b1, 16, 1, 0, 1'b0, 64'h0);
    repeat (20) cyc(1'b1, 4, 4, 0, 1'b0, {$urandom, $urandom});
    cyc(1'b0, 0, 0, 0, 1'b1, 64'h1111_2222_3333_4444);
    cyc(1'b0, 0, 0, 0, 1'b0, 64'hdead_beef_dead_beef);
    cyc(1'b0, 0, 0, 0, 1'b0, 64'hdead_beef_dead_beef);
    cyc(1'b0, 0, 0, 0, 1'b1, 64'h5555_6666_7777_8888);
    chk("t3_writes", seen_en.size(), 2);
    if (seen_en.size() == 2) begin
      chk("t3_en0", seen_en[0], 32'h0000_00FF);
      chk("t3_en1", seen_en[1], 32'h0000_FF00);
    end
    cyc(1'b0, 0, 0, 0, 1'b1, 64'h0);

    // reset mid-map after three accepts
    cyc(1'b1, 32, 2, 40, 1'b0, 64'h0);
    repeat (3) cyc(1'b0, 0, 0, 0, 1'b1, {$urandom, $urandom});
    chk("t6_pre_en", (wr_en != '0), 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_en", wr_en, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", in_ready, 0);
    m_run = 1'b0;
    sb.delete();
    #2;
    rst = 1'b0;
    @(negedge clk);
    clear_seen();
    cyc(1'b1, 32, 1, 40, 1'b0, 64'h0);
    cyc(1'b0, 0, 0, 0, 1'b1, 64'h0102_0304_0506_0708);
    if (seen_en.size() == 1) begin
      chk("t6_first_en", seen_en[0], 32'h0000_00FF);
      chk("t6_first_addr", seen_addr[0], 40);
    end else begin
      chk("t6_first_writes", seen_en.size(), 1);
    end
    repeat (3) cyc(1'b0, 0, 0, 0, 1'b1, {$urandom, $urandom});
    cyc(1'b0, 0, 0, 0, 1'b0, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
